// File: rtl/vdma_fbuf_pkg.sv
// Shared types and helpers for the VDMA triple-buffer base-address scheduler.
package vdma_fbuf_pkg;

    localparam int unsigned NBUF = 3;

    typedef logic [1:0] fbuf_idx_t;

    // Lowest buffer index that is neither a nor b.
    function automatic fbuf_idx_t fbuf_pick_free(fbuf_idx_t a, fbuf_idx_t b);
        fbuf_idx_t r;
        r = 2'd0;
        for (int i = int'(NBUF) - 1; i >= 0; i--) begin
            if (2'(i) != a && 2'(i) != b) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vdma_fbuf_ch_sched.sv
// One channel of the triple-buffer scheduler: buffer ownership and registered base addresses.
// Optional FBUF_REPEAT_CNT_EN exposes a repeat-frame strobe for the top-level counter.
module vdma_fbuf_ch_sched
    import vdma_fbuf_pkg::*;
#(
    parameter int unsigned ASIZE      = 29,
    parameter int unsigned FRAME_STEP = 180 * 8 * 1080
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [ASIZE-1:0] region_base,
    input  logic             wr_start,
    input  logic             rd_start,
`ifdef FBUF_REPEAT_CNT_EN
    output logic             rd_repeat_c,
`endif
    output logic [ASIZE-1:0] wr_addr,
    output logic [ASIZE-1:0] rd_addr,
    output logic             new_frame
);

    localparam logic [ASIZE-1:0] STEP1 = ASIZE'(FRAME_STEP);
    localparam logic [ASIZE-1:0] STEP2 = ASIZE'(2 * FRAME_STEP);

    function automatic logic [ASIZE-1:0] buf_offset(fbuf_idx_t idx);
        case (idx)
            2'd1:    return STEP1;
            2'd2:    return STEP2;
            default: return '0;
        endcase
    endfunction

    fbuf_idx_t        wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, done_idx_q, done_idx_d;
    logic             done_valid_q, done_valid_d;
    logic [ASIZE-1:0] base_wr_q, base_wr_d, base_rd_q, base_rd_d;
    logic [ASIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic             new_frame_q, new_frame_d;

    // Read side resolves first so the writer avoids the buffer the reader is about to own.
    always_comb begin
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        done_idx_d   = done_idx_q;
        done_valid_d = done_valid_q;
        base_wr_d    = base_wr_q;
        base_rd_d    = base_rd_q;
        new_frame_d  = 1'b0;
        if (!enable) begin
            wr_idx_d     = 2'd0;
            rd_idx_d     = 2'd0;
            done_valid_d = 1'b0;
            base_wr_d    = region_base;
            base_rd_d    = region_base;
        end else begin
            if (rd_start) begin
                base_rd_d = region_base;
                if (wr_start) begin
                    rd_idx_d     = wr_idx_q;
                    done_valid_d = 1'b0;
                    new_frame_d  = 1'b1;
                end else if (done_valid_q) begin
                    rd_idx_d     = done_idx_q;
                    done_valid_d = 1'b0;
                    new_frame_d  = 1'b1;
                end
            end
            if (wr_start) begin
                base_wr_d  = region_base;
                done_idx_d = wr_idx_q;
                wr_idx_d   = fbuf_pick_free(wr_idx_q, rd_idx_d);
                if (!rd_start) begin
                    done_valid_d = 1'b1;
                end
            end
        end
        wr_addr_d = base_wr_d + buf_offset(wr_idx_d);
        rd_addr_d = base_rd_d + buf_offset(rd_idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q     <= 2'd0;
            rd_idx_q     <= 2'd0;
            done_idx_q   <= 2'd0;
            done_valid_q <= 1'b0;
            base_wr_q    <= '0;
            base_rd_q    <= '0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            new_frame_q  <= 1'b0;
        end else begin
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            done_idx_q   <= done_idx_d;
            done_valid_q <= done_valid_d;
            base_wr_q    <= base_wr_d;
            base_rd_q    <= base_rd_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            new_frame_q  <= new_frame_d;
        end
    end

`ifdef FBUF_REPEAT_CNT_EN
    // A read start with no completed frame pending re-reads the current buffer.
    assign rd_repeat_c = enable & rd_start & ~wr_start & ~done_valid_q;
`endif

    assign wr_addr   = wr_addr_q;
    assign rd_addr   = rd_addr_q;
    assign new_frame = new_frame_q;

endmodule

// File: rtl/vdma_fbuf_baseaddr_sched.sv
// Per-channel triple-buffer scheduler feeding the multiport VDMA base-address inputs.
// Define FBUF_REPEAT_CNT_EN to add the per-channel saturating rd_repeat_cnt outputs.
module vdma_fbuf_baseaddr_sched
    import vdma_fbuf_pkg::*;
#(
    parameter int unsigned ASIZE      = 29,
    parameter int unsigned NCH        = 8,
    parameter int unsigned FRAME_STEP = 180 * 8 * 1080
) (
    input  logic             axi_aclk,
    input  logic             axi_reset,
    input  logic [NCH-1:0]   ch_enable,
    input  logic [ASIZE-1:0] ch_region_base [NCH],
    input  logic [NCH-1:0]   wr_frame_start,
    input  logic [NCH-1:0]   rd_frame_start,
`ifdef FBUF_REPEAT_CNT_EN
    output logic [15:0]      rd_repeat_cnt  [NCH],
`endif
    output logic [ASIZE-1:0] wr_baseaddr    [NCH],
    output logic [ASIZE-1:0] rd_baseaddr    [NCH],
    output logic [NCH-1:0]   rd_new_frame
);

`ifdef FBUF_REPEAT_CNT_EN
    logic [NCH-1:0] rd_repeat_c;
    logic [15:0]    repeat_cnt_q [NCH];
    logic [15:0]    repeat_cnt_d [NCH];
`endif

    for (genvar g = 0; g < int'(NCH); g++) begin : g_ch
        vdma_fbuf_ch_sched #(
            .ASIZE      (ASIZE),
            .FRAME_STEP (FRAME_STEP)
        ) u_ch (
            .clk         (axi_aclk),
            .rst         (axi_reset),
            .enable      (ch_enable[g]),
            .region_base (ch_region_base[g]),
            .wr_start    (wr_frame_start[g]),
            .rd_start    (rd_frame_start[g]),
`ifdef FBUF_REPEAT_CNT_EN
            .rd_repeat_c (rd_repeat_c[g]),
`endif
            .wr_addr     (wr_baseaddr[g]),
            .rd_addr     (rd_baseaddr[g]),
            .new_frame   (rd_new_frame[g])
        );
    end

`ifdef FBUF_REPEAT_CNT_EN
    // Saturating repeat-frame counters, cleared while the channel is parked.
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            repeat_cnt_d[i] = repeat_cnt_q[i];
            if (!ch_enable[i]) begin
                repeat_cnt_d[i] = 16'd0;
            end else if (rd_repeat_c[i] && repeat_cnt_q[i] != 16'hFFFF) begin
                repeat_cnt_d[i] = repeat_cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        for (int i = 0; i < int'(NCH); i++) begin
            if (axi_reset) begin
                repeat_cnt_q[i] <= 16'd0;
            end else begin
                repeat_cnt_q[i] <= repeat_cnt_d[i];
            end
        end
    end

    assign rd_repeat_cnt = repeat_cnt_q;
`endif

endmodule
